// File: rtl/my_packer_pkg.sv
// Shared defaults and helpers for the beat packer.
// Sizes the beat counter from the number of beats per word.
package my_packer_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_RATIO = 4;

    // Counter width for 0..ratio-1, never narrower than one bit.
    function automatic int CNT_W(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/my_beat_packer.sv
// Packs RATIO upstream beats of DW bits into one DW*RATIO word, first beat in the low lane.
// Optional flush on a short word when MY_PACKER_FLUSH_EN is defined (adds up_last / dn_keep).
module my_beat_packer
    import my_packer_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int RATIO = DEFAULT_RATIO
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DW-1:0]         up_bus,
    input  logic                  up_val,
    output logic                  up_rdy,
`ifdef MY_PACKER_FLUSH_EN
    input  logic                  up_last,
    output logic [RATIO-1:0]      dn_keep,
`endif
    output logic [DW*RATIO-1:0]   dn_bus,
    output logic                  dn_val,
    input  logic                  dn_rdy
);

    localparam int            CW       = CNT_W(RATIO);
    localparam int            WW       = DW * RATIO;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    logic [CW-1:0]    cnt_p0;
    logic [WW-1:0]    acc_p0;
    logic [WW-1:0]    word_p1;
    logic             vld_p1;

    logic             last_beat;
    logic             beat_fire;
    logic             word_done;
    logic [WW-1:0]    merged;

`ifdef MY_PACKER_FLUSH_EN
    logic [RATIO-1:0] keep_p1;
    logic [RATIO-1:0] keep_next;
`endif

    // A word-closing beat is only refused when the output register is still occupied.
    always_comb begin
        last_beat = (cnt_p0 == LAST_CNT);
`ifdef MY_PACKER_FLUSH_EN
        last_beat = last_beat || up_last;
`endif
        up_rdy    = !(last_beat && vld_p1 && !dn_rdy);
        beat_fire = up_val && up_rdy;
        word_done = beat_fire && last_beat;

        merged = acc_p0;
        for (int k = 0; k < RATIO; k++) begin
            if (k == int'(cnt_p0)) begin
                merged[k*DW +: DW] = up_bus;
            end
        end
    end

`ifdef MY_PACKER_FLUSH_EN
    always_comb begin
        keep_next = '0;
        for (int k = 0; k < RATIO; k++) begin
            keep_next[k] = (k <= int'(cnt_p0));
        end
    end
`endif

    // Stage p0: accumulator; cleared on word completion so flushed words carry zero lanes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_p0 <= '0;
            acc_p0 <= '0;
        end else if (beat_fire) begin
            if (last_beat) begin
                cnt_p0 <= '0;
                acc_p0 <= '0;
            end else begin
                cnt_p0 <= cnt_p0 + CW'(1);
                acc_p0 <= merged;
            end
        end
    end

    // Stage p1: output register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_p1  <= 1'b0;
            word_p1 <= '0;
`ifdef MY_PACKER_FLUSH_EN
            keep_p1 <= '0;
`endif
        end else if (word_done) begin
            vld_p1  <= 1'b1;
            word_p1 <= merged;
`ifdef MY_PACKER_FLUSH_EN
            keep_p1 <= keep_next;
`endif
        end else if (dn_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

    assign dn_bus = word_p1;
    assign dn_val = vld_p1;
`ifdef MY_PACKER_FLUSH_EN
    assign dn_keep = keep_p1;
`endif

endmodule

// File: tb/tb_my_beat_packer.sv
// Randomised and directed bench for my_beat_packer (DW=8, RATIO=4) against a queue-based packing model.
// Flush cases run only when MY_PACKER_FLUSH_EN is defined.
module tb_my_beat_packer;

    localparam int DW    = 8;
    localparam int RATIO = 4;
    localparam int WW    = DW * RATIO;

    logic           i_clk     = 1'b0;
    logic           i_reset_n = 1'b0;
    logic [DW-1:0]  up_bus    = '0;
    logic           up_val    = 1'b0;
    logic           dn_rdy    = 1'b0;
    logic           up_rdy;
    logic [WW-1:0]  dn_bus;
    logic           dn_val;
`ifdef MY_PACKER_FLUSH_EN
    logic             up_last = 1'b0;
    logic [RATIO-1:0] dn_keep;
`endif

    my_beat_packer #(.DW(DW), .RATIO(RATIO)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .up_bus    (up_bus),
        .up_val    (up_val),
        .up_rdy    (up_rdy),
`ifdef MY_PACKER_FLUSH_EN
        .up_last   (up_last),
        .dn_keep   (dn_keep),
`endif
        .dn_bus    (dn_bus),
        .dn_val    (dn_val),
        .dn_rdy    (dn_rdy)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: lanes filled so far, plus a queue of words owed downstream.
    logic [WW-1:0]    m_acc = '0;
    int               m_cnt = 0;
    logic [WW-1:0]    word_q[$];
    logic [RATIO-1:0] keep_q[$];
    bit               prev_stall = 0;
    logic [WW-1:0]    prev_bus = '0;
    int               n_beats = 0;
    int               n_words = 0;

    // Drive one cycle's inputs, compare against the model just before the edge, then advance.
    task automatic step(input logic v, input logic [DW-1:0] b, input logic r);
        bit               lst;
        bit               pend;
        bit               exp_rdy;
        logic [RATIO-1:0] kv;
        up_val = v;
        up_bus = b;
        dn_rdy = r;
        #1;
        lst = 0;
`ifdef MY_PACKER_FLUSH_EN
        lst = up_last;
`endif
        pend    = (word_q.size() != 0);
        exp_rdy = !(((m_cnt == RATIO - 1) || lst) && pend && !r);
        check("dn_val", dn_val, pend);
        check("up_rdy", up_rdy, exp_rdy);
        if (prev_stall) check("stall hold", dn_bus, prev_bus);
        if (pend) begin
            check("dn_bus", dn_bus, word_q[0]);
`ifdef MY_PACKER_FLUSH_EN
            check("dn_keep", dn_keep, keep_q[0]);
`endif
        end
        prev_stall = pend && !r;
        prev_bus   = dn_bus;
        if (pend && r) begin
            void'(word_q.pop_front());
            void'(keep_q.pop_front());
            n_words++;
        end
        if (v && exp_rdy) begin
            m_acc[m_cnt*DW +: DW] = b;
            m_cnt++;
            n_beats++;
            if (m_cnt == RATIO || lst) begin
                kv = '0;
                for (int k = 0; k < m_cnt; k++) kv[k] = 1'b1;
                word_q.push_back(m_acc);
                keep_q.push_back(kv);
                m_acc = '0;
                m_cnt = 0;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        up_val    = 1'b0;
        i_reset_n = 1'b0;
        #1;
        check("rst dn_val", dn_val, 1'b0);
        check("rst dn_bus", dn_bus, '0);
        check("rst up_rdy", up_rdy, 1'b1);
`ifdef MY_PACKER_FLUSH_EN
        check("rst dn_keep", dn_keep, '0);
`endif
        m_acc      = '0;
        m_cnt      = 0;
        prev_stall = 0;
        word_q.delete();
        keep_q.delete();
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int cycles;
        int beats0;
        int words0;

        do_reset();

        // Back-to-back beats with dn_rdy high: one-cycle word pulse.
        step(1, 8'h11, 1); step(1, 8'h22, 1); step(1, 8'h33, 1); step(1, 8'h44, 1);
        check("d29 val", dn_val, 1'b1);
        check("d29 word", dn_bus, 32'h4433_2211);
        step(0, 8'h00, 1);
        check("d29 pulse", dn_val, 1'b0);

        // Stalled downstream: final beat blocked, then released with no bubble.
        step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
        step(1, 8'h55, 0); step(1, 8'h66, 0); step(1, 8'h77, 0);
        step(1, 8'h88, 0);
        check("d30 hold", dn_bus, 32'h4433_2211);
        up_val = 1'b1; up_bus = 8'h88; dn_rdy = 1'b0;
        #1;
        check("d30 up_rdy", up_rdy, 1'b0);
        @(negedge i_clk);
        step(1, 8'h88, 1);
        check("d30 nobubble val", dn_val, 1'b1);
        check("d30 nobubble word", dn_bus, 32'h8877_6655);
        step(0, 8'h00, 1);
        check("d30 drained", dn_val, 1'b0);

        // Gaps between beats.
        step(1, 8'hA0, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);
        step(1, 8'hB0, 1); step(0, 8'h00, 1);
        step(1, 8'hC0, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);
        step(1, 8'hD0, 1);
        check("d31 word", dn_bus, 32'hD0C0_B0A0);
        step(0, 8'h00, 1);

        // Reset mid-word discards the partial beats.
        step(1, 8'h01, 1); step(1, 8'h02, 1);
        do_reset();
        step(1, 8'h0A, 1); step(1, 8'h0B, 1); step(1, 8'h0C, 1); step(1, 8'h0D, 1);
        check("d32 word", dn_bus, 32'h0D0C_0B0A);
        step(0, 8'h00, 1);

`ifdef MY_PACKER_FLUSH_EN
        step(1, 8'hA1, 1);
        up_last = 1'b1;
        step(1, 8'hB2, 1);
        up_last = 1'b0;
        check("d33 short word", dn_bus, 32'h0000_B2A1);
        check("d33 short keep", dn_keep, 4'b0011);
        step(1, 8'h01, 1); step(1, 8'h02, 1); step(1, 8'h03, 1); step(1, 8'h04, 1);
        check("d33 full keep", dn_keep, 4'b1111);
        check("d33 full word", dn_bus, 32'h0403_0201);
        step(0, 8'h00, 1);
`endif

        // Random traffic against the model.
        beats0 = n_beats;
        words0 = n_words;
        cycles = 0;
        while (!((n_beats - beats0) >= 1000 && m_cnt == 0) && cycles < 20000) begin
            step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 2) != 0));
            cycles++;
        end
        check("rand in budget", (cycles < 20000), 1'b1);
        repeat (4) step(0, 8'h00, 1);
        check("rand drained", word_q.size(), 0);
        check("rand no loss", (n_words - words0) * RATIO, n_beats - beats0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/my_beat_packer.md
MY_BEAT_PACKER -- requirements
Module: my_beat_packer

Interface
REQ-001 SHALL have parameter DW, default 8, giving the upstream beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, giving the number of beats per output word (legal values 2..16).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port up_bus, input, DW bits: upstream beat data, fed by the skid stage's dn_bus_slave.
REQ-006 SHALL have port up_val, input, 1 bit: upstream beat valid, fed by the skid stage's dn_val_slave.
REQ-007 SHALL have port up_rdy, output, 1 bit: packer can accept a beat; drives the skid stage's dn_rdy_next_stage.
REQ-008 SHALL have port dn_bus, output, DW*RATIO bits: packed word.
REQ-009 SHALL have port dn_val, output, 1 bit: packed word valid.
REQ-010 SHALL have port dn_rdy, input, 1 bit: downstream accepts the word.

Function
REQ-011 SHALL transfer a beat only when up_val and up_rdy are both high at a rising edge; the same rule applies to words on dn_val/dn_rdy.
REQ-012 SHALL place beat k of a word (k = 0..RATIO-1) in dn_bus[k*DW +: DW], so the first beat lands in the least-significant lane.
REQ-013 SHALL hold partial words in an accumulator with a beat counter cnt (0..RATIO-1) that wraps to 0 after the last beat is accepted.
REQ-014 SHALL move the completed word into a separate output register, raising dn_val in the cycle after the last beat is accepted (latency 1 cycle).
REQ-015 SHALL keep dn_bus and dn_val stable while dn_val=1 and dn_rdy=0.
REQ-016 SHALL drive up_rdy = !(cnt==RATIO-1 && dn_val && !dn_rdy), a combinational function of dn_rdy; beats 0..RATIO-2 are always accepted.
REQ-017 SHALL, when a word is accepted downstream in the same edge as a final beat arrives, load the new word and keep dn_val=1 with no bubble.
REQ-018 SHALL sustain one beat per cycle when dn_rdy is held high.
REQ-019 SHALL clear dn_val after a downstream accept when no new word completes in that edge.
REQ-020 SHALL leave cnt and the accumulator unchanged by gaps (up_val=0).

Reset
REQ-021 SHALL, while i_reset_n=0, asynchronously force dn_val=0, dn_bus=0, cnt=0 and accumulator=0; up_rdy then evaluates to 1.
REQ-022 SHALL discard any partial or pending word on reset mid-operation; the first beat accepted after release is beat 0.

Configuration
REQ-023 SHALL, when macro MY_PACKER_FLUSH_EN is defined, add input up_last (1 bit) and output dn_keep (RATIO bits).
REQ-024 SHALL, with MY_PACKER_FLUSH_EN defined, emit the word after a beat accepted with up_last=1:
- unfilled lanes are zero;
- dn_keep has one bit set per filled lane (bit k = lane k);
- cnt resets to 0;
- up_rdy uses (cnt==RATIO-1 || up_last) in place of (cnt==RATIO-1) in REQ-016.
REQ-025 SHALL, with MY_PACKER_FLUSH_EN defined, drive dn_keep to all-ones for full words and to 0 at reset.
REQ-026 SHALL, without MY_PACKER_FLUSH_EN, have neither port and emit full words only.

Structure
REQ-027 SHALL take default DW and RATIO and the function CNT_W = $clog2(RATIO) from shared package my_packer_pkg.
REQ-028 SHALL be a single module with no sub-module; the accumulator and output register are local.

Verification (DW=8, RATIO=4)
REQ-029 SHALL cover: dn_rdy=1; beats 0x11,0x22,0x33,0x44 on consecutive cycles -> dn_bus=0x44332211 with dn_val=1 for exactly one cycle, one cycle after beat 0x44.
REQ-030 SHALL cover: dn_rdy=0; beats 0x11..0x88 -> first word holds at 0x44332211, up_rdy=0 while beat 0x88 is offered; when dn_rdy rises, the next word is 0x88776655 with no bubble.
REQ-031 SHALL cover: beats 0xA0,0xB0,0xC0,0xD0 with idle cycles between them -> dn_bus=0xD0C0B0A0 and no spurious dn_val.
REQ-032 SHALL cover: assert i_reset_n=0 after 0x01,0x02; release, then send 0x0A,0x0B,0x0C,0x0D -> dn_bus=0x0D0C0B0A.
REQ-033 SHALL cover, with MY_PACKER_FLUSH_EN defined: 0xA1 then 0xB2 with up_last=1 -> dn_bus=0x0000B2A1, dn_keep=4'b0011; the next full word has dn_keep=4'b1111.
REQ-034 SHALL cover: a random up_val/dn_rdy stream of 1000 beats -> the output matches a reference packing model, dn_bus never changes while stalled, and no beats are lost.
